// File: rtl/sd_cmd_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_tx_ctrl
// Brief    : Serialises one 48-bit SD command frame (with CRC-7) onto CMD.
// Revision : 1.0
// ============================================================================
module sd_cmd_tx_ctrl #(
  parameter int GAP_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bit_en,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] argument,
  output logic        cmd_out,
  output logic        cmd_oe,
  output logic        busy,
  output logic        done,
  output logic [6:0]  crc_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CRC  = 3'd2,
    S_END  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [5:0] c_HDR_LAST = 6'd39;
  localparam logic [5:0] c_CRC_LAST = 6'd46;
  localparam logic [7:0] c_GAP_LAST = (GAP_BITS == 0) ? 8'd0 : 8'(GAP_BITS - 1);

  state_t      r_state;
  logic [39:0] r_shift;
  logic [6:0]  r_crc;
  logic [6:0]  r_crc_sh;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_cmd_out;
  logic        r_cmd_oe;
  logic        r_busy;
  logic        r_done;

  logic        w_inv;
  logic [6:0]  w_crc_next;

  always_comb begin
    w_inv      = r_cmd_out ^ r_crc[6];
    w_crc_next = {r_crc[5:3], r_crc[2] ^ w_inv, r_crc[1:0], w_inv};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_crc     <= '0;
      r_crc_sh  <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_cmd_out <= 1'b1;
      r_cmd_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start landing on the done cycle is dropped, not deferred.
          if (start && !r_done) begin
            r_shift   <= {2'b01, cmd_index, argument};
            r_crc     <= '0;
            r_crc_sh  <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_state   <= S_HDR;
            r_busy    <= 1'b1;
            r_cmd_oe  <= 1'b1;
            r_cmd_out <= 1'b0;
          end
        end
        S_HDR: begin
          if (bit_en) begin
            r_crc     <= w_crc_next;
            r_shift   <= {r_shift[38:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == c_HDR_LAST) begin
              r_state   <= S_CRC;
              r_crc_sh  <= w_crc_next;
              r_cmd_out <= w_crc_next[6];
            end else begin
              r_cmd_out <= r_shift[38];
            end
          end
        end
        S_CRC: begin
          // Shift a copy so crc_out stays readable for the rest of the frame.
          if (bit_en) begin
            r_crc_sh  <= {r_crc_sh[5:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == c_CRC_LAST) begin
              r_state   <= S_END;
              r_cmd_out <= 1'b1;
            end else begin
              r_cmd_out <= r_crc_sh[5];
            end
          end
        end
        S_END: begin
          if (bit_en) begin
            r_cmd_out <= 1'b1;
            if (GAP_BITS == 0) begin
              r_state  <= S_IDLE;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_cmd_oe <= 1'b0;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        S_GAP: begin
          if (bit_en) begin
            if (r_gap_cnt == c_GAP_LAST) begin
              r_state   <= S_IDLE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_cmd_oe  <= 1'b0;
              r_cmd_out <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_out = r_cmd_out;
  assign cmd_oe  = r_cmd_oe;
  assign busy    = r_busy;
  assign done    = r_done;
  assign crc_out = r_crc;

endmodule
`default_nettype wire
